// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths and drain FSM encoding for the store buffer
package store_buffer_pkg;

    localparam int ARCH_BITS     = 32;
    localparam int SB_SLOTS      = 4;
    localparam int SB_IDX_BITS   = 2;
    localparam int BYTE_IDX_BITS = 2;
    localparam int SB_TAG_BITS   = ARCH_BITS - BYTE_IDX_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-match priority scan over the buffered word tags
//   i_tags  : per-slot word tags (address with byte offset stripped)
//   i_head  : oldest slot index
//   i_count : number of valid slots, scanned from i_head upward
//   i_key   : word tag of the load being looked up
//   o_match : some valid slot holds i_key
//   o_idx   : slot of the youngest such entry
module sb_fwd_match #(
    parameter int N  = 4,
    parameter int IB = 2,
    parameter int TW = 30
) (
    input  logic [TW-1:0] i_tags [N],
    input  logic [IB-1:0] i_head,
    input  logic [IB:0]   i_count,
    input  logic [TW-1:0] i_key,
    output logic          o_match,
    output logic [IB-1:0] o_idx
);

    // Walking oldest to youngest lets later hits overwrite earlier ones; the
    // IB-bit index sum wraps naturally because N is a power of two.
    always_comb begin
        o_match = 1'b0;
        o_idx   = i_head;
        for (int k = 0; k < N; k++) begin
            if ((IB + 1)'(k) < i_count && i_tags[i_head + IB'(k)] == i_key) begin
                o_match = 1'b1;
                o_idx   = i_head + IB'(k);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: post-commit store FIFO draining to the dCache with load forwarding
//   push/pushAddr/pushData/pushByte : committed store from the ROB
//   full/empty/overflow             : occupancy status, overflow is sticky
//   memReq/memAddr/memData/memByte  : head store offered to the dCache
//   memAck                          : dCache took the head store
//   lookupReq/lookupAddr            : load forwarding query
//   lookupHit/lookupData/lookupAddrOut/lookupByte : youngest matching store
module store_buffer
    import store_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [ARCH_BITS-1:0] pushAddr,
    input  logic [ARCH_BITS-1:0] pushData,
    input  logic                 pushByte,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 memReq,
    output logic [ARCH_BITS-1:0] memAddr,
    output logic [ARCH_BITS-1:0] memData,
    output logic                 memByte,
    input  logic                 memAck,
    input  logic                 lookupReq,
    input  logic [ARCH_BITS-1:0] lookupAddr,
    output logic                 lookupHit,
    output logic [ARCH_BITS-1:0] lookupData,
    output logic [ARCH_BITS-1:0] lookupAddrOut,
    output logic                 lookupByte
);

    localparam int CW = SB_IDX_BITS + 1;

    logic [ARCH_BITS-1:0]   r_addr [SB_SLOTS];
    logic [ARCH_BITS-1:0]   r_data [SB_SLOTS];
    logic [SB_SLOTS-1:0]    r_byte;
    logic [SB_IDX_BITS-1:0] r_head;
    logic [SB_IDX_BITS-1:0] r_tail;
    logic [CW-1:0]          r_count;
    sb_state_e              r_state;
    logic                   r_overflow;

    logic [CW-1:0]          w_count_nxt;
    logic                   w_push_ok;
    logic                   w_pop;
    logic                   w_match;
    logic [SB_IDX_BITS-1:0] w_sel;
    logic [SB_TAG_BITS-1:0] w_tags [SB_SLOTS];
    logic                   w_unused;

    assign full        = r_count == CW'(SB_SLOTS);
    assign empty       = r_count == '0;
    assign w_push_ok   = push && !full;
    assign w_pop       = r_state == S_REQ && memAck;
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);

    // Entry payloads carry no reset; validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_addr[r_tail] <= pushAddr;
            r_data[r_tail] <= pushData;
            r_byte[r_tail] <= pushByte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= S_IDLE;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push_ok) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            if (push && full) r_overflow <= 1'b1;
            // Stay in S_REQ across acks while entries remain, giving bubble-free drain.
            r_state <= (r_state == S_IDLE) ? (r_count != '0 ? S_REQ : S_IDLE)
                                           : (w_pop && w_count_nxt == '0 ? S_IDLE : S_REQ);
        end
    end

    assign overflow = r_overflow;
    assign memReq   = r_state == S_REQ;
    assign memAddr  = r_addr[r_head];
    assign memData  = r_data[r_head];
    assign memByte  = r_byte[r_head];

    for (genvar g = 0; g < SB_SLOTS; g++) begin : g_tag
        assign w_tags[g] = r_addr[g][ARCH_BITS-1:BYTE_IDX_BITS];
    end

    sb_fwd_match #(
        .N  (SB_SLOTS),
        .IB (SB_IDX_BITS),
        .TW (SB_TAG_BITS)
    ) u_fwd (
        .i_tags  (w_tags),
        .i_head  (r_head),
        .i_count (r_count),
        .i_key   (lookupAddr[ARCH_BITS-1:BYTE_IDX_BITS]),
        .o_match (w_match),
        .o_idx   (w_sel)
    );

    // Forwarding compares whole words only; the byte offset does not take part.
    assign w_unused      = ^lookupAddr[BYTE_IDX_BITS-1:0];
    assign lookupHit     = lookupReq && w_match;
    assign lookupData    = r_data[w_sel];
    assign lookupAddrOut = r_addr[w_sel];
    assign lookupByte    = r_byte[w_sel];

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, push, pushByte, memAck, lookupReq;
    logic [31:0] pushAddr, pushData, lookupAddr;
    logic        full, empty, overflow, memReq, memByte, lookupHit, lookupByte;
    logic [31:0] memAddr, memData, lookupData, lookupAddrOut;

    store_buffer dut (
        .clk(clk), .rst(rst), .push(push), .pushAddr(pushAddr), .pushData(pushData),
        .pushByte(pushByte), .full(full), .empty(empty), .overflow(overflow),
        .memReq(memReq), .memAddr(memAddr), .memData(memData), .memByte(memByte),
        .memAck(memAck), .lookupReq(lookupReq), .lookupAddr(lookupAddr),
        .lookupHit(lookupHit), .lookupData(lookupData), .lookupAddrOut(lookupAddrOut),
        .lookupByte(lookupByte)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } st_t;

    st_t q[$];
    bit  m_ovf, m_req;
    int  n_pass, n_total;

    // Reference: an in-order queue of committed stores; the drain request rises
    // one cycle after the queue is seen non-empty and falls when the last entry is acked.
    task automatic tick();
        int  n0 = q.size();
        bit  pop = m_req && memAck;
        bit  f = (n0 == SB_SLOTS);
        st_t e;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_req = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push && !f) begin
                e.a = pushAddr; e.d = pushData; e.b = pushByte;
                q.push_back(e);
            end
            if (push && f) m_ovf = 1;
            m_req = m_req ? !(pop && q.size() == 0) : (n0 != 0);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit mlook(input logic [31:0] a, output st_t e);
        e.a = 'x; e.d = 'x; e.b = 1'bx;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a[31:2] == a[31:2]) begin
                e = q[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic drive(input bit p, input logic [31:0] a, input logic [31:0] d, input bit b, input bit ack);
        push = p; pushAddr = a; pushData = d; pushByte = b; memAck = ack;
    endtask

    task automatic drain_all();
        int n = 0;
        memAck = 1'b1; push = 1'b0;
        while (!empty && n < 20) begin
            tick();
            n++;
        end
        memAck = 1'b0;
        #1;
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; lookupReq = 1'b1; lookupAddr = 32'h0;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        n_total++; if (memReq !== 1'b0) $display("FAIL reset_memReq got=%b exp=0", memReq); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
        n_total++; if (lookupHit !== 1'b0) $display("FAIL reset_lookupHit got=%b exp=0", lookupHit); else n_pass++;
        lookupReq = 1'b0;
    endtask

    task automatic test_single();
        drive(1, 32'h100, 32'hDEAD_BEEF, 0, 0);
        tick();
        push = 1'b0;
        #1;
        n_total++; if (memReq !== 1'b0) $display("FAIL single_req_early got=%b exp=0", memReq); else n_pass++;
        tick();
        n_total++; if (memReq !== 1'b1) $display("FAIL single_req got=%b exp=1", memReq); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (memAddr !== 32'h100 || memData !== 32'hDEAD_BEEF || memByte !== 1'b0 || memReq !== 1'b1)
                $display("FAIL single_hold%0d got=%h/%h/%b/%b exp=100/deadbeef/0/1", i, memAddr, memData, memByte, memReq);
            else n_pass++;
            tick();
        end
        memAck = 1'b1;
        tick();
        memAck = 1'b0;
        #1;
        n_total++; if (memReq !== 1'b0 || empty !== 1'b1) $display("FAIL single_done got req=%b empty=%b exp=0/1", memReq, empty); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 0, 0);
            tick();
        end
        push = 1'b0;
        #1;
        n_total++; if (full !== 1'b1 || overflow !== 1'b0) $display("FAIL fill_full got full=%b ovf=%b exp=1/0", full, overflow); else n_pass++;
        drive(1, 32'h20, 32'hFF, 0, 0);
        tick();
        push = 1'b0;
        #1;
        n_total++; if (overflow !== 1'b1 || full !== 1'b1) $display("FAIL fill_overflow got ovf=%b full=%b exp=1/1", overflow, full); else n_pass++;
        memAck = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (memReq !== 1'b1 || memAddr !== 32'h10 + 32'(4 * i))
                $display("FAIL fill_drain%0d got req=%b addr=%h exp=1/%h", i, memReq, memAddr, 32'h10 + 32'(4 * i));
            else n_pass++;
            tick();
        end
        memAck = 1'b0;
        #1;
        n_total++; if (memReq !== 1'b0 || empty !== 1'b1) $display("FAIL fill_end got req=%b empty=%b exp=0/1", memReq, empty); else n_pass++;
    endtask

    task automatic test_forward();
        drive(1, 32'h200, 32'h11, 0, 0); tick();
        drive(1, 32'h204, 32'h22, 0, 0); tick();
        drive(1, 32'h201, 32'h33, 1, 0); tick();
        push = 1'b0; lookupReq = 1'b1; lookupAddr = 32'h202;
        #1;
        n_total++; if (lookupHit !== 1'b1 || lookupData !== 32'h33 || lookupAddrOut !== 32'h201 || lookupByte !== 1'b1)
            $display("FAIL fwd_202 got %b/%h/%h/%b exp=1/33/201/1", lookupHit, lookupData, lookupAddrOut, lookupByte);
        else n_pass++;
        lookupAddr = 32'h208;
        #1;
        n_total++; if (lookupHit !== 1'b0) $display("FAIL fwd_208 got=%b exp=0", lookupHit); else n_pass++;
        lookupAddr = 32'h202; lookupReq = 1'b0;
        #1;
        n_total++; if (lookupHit !== 1'b0) $display("FAIL fwd_noreq got=%b exp=0", lookupHit); else n_pass++;
        lookupReq = 1'b1; lookupAddr = 32'h20C;
        drive(1, 32'h20C, 32'h44, 0, 0);
        #1;
        n_total++; if (lookupHit !== 1'b0) $display("FAIL fwd_same_cycle got=%b exp=0", lookupHit); else n_pass++;
        tick();
        push = 1'b0;
        #1;
        n_total++; if (lookupHit !== 1'b1 || lookupData !== 32'h44) $display("FAIL fwd_next_cycle got %b/%h exp=1/44", lookupHit, lookupData); else n_pass++;
        lookupReq = 1'b0;
        drain_all();
    endtask

    task automatic test_simul();
        int n = 0;
        drive(1, 32'h500, 32'h50, 0, 0); tick();
        drive(1, 32'h504, 32'h54, 0, 0); tick();
        push = 1'b0;
        #1;
        while (!memReq && n < 10) begin tick(); n++; end
        n_total++; if (memReq !== 1'b1) $display("FAIL simul_wait got=%b exp=1", memReq); else n_pass++;
        drive(1, 32'h508, 32'h58, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        lookupReq = 1'b1; lookupAddr = 32'h508;
        #1;
        n_total++; if (memAddr !== 32'h504 || full !== 1'b0 || empty !== 1'b0)
            $display("FAIL simul_head got addr=%h full=%b empty=%b exp=504/0/0", memAddr, full, empty);
        else n_pass++;
        n_total++; if (lookupHit !== 1'b1 || lookupData !== 32'h58) $display("FAIL simul_tail got %b/%h exp=1/58", lookupHit, lookupData); else n_pass++;
        lookupReq = 1'b0;
        memAck = 1'b1; tick();
        n_total++; if (memAddr !== 32'h508 || empty !== 1'b0) $display("FAIL simul_second got addr=%h empty=%b exp=508/0", memAddr, empty); else n_pass++;
        tick();
        memAck = 1'b0;
        #1;
        n_total++; if (empty !== 1'b1) $display("FAIL simul_count got empty=%b exp=1", empty); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            drive(1, 32'h600 + 32'(8 * i), d, 1'(i & 1), memReq);
            tick();
            drive(0, 0, 0, 0, 0);
            lookupReq = 1'b1; lookupAddr = 32'h600 + 32'(8 * i) + 32'(i % 4);
            #1;
            n_total++; if (lookupHit !== 1'b1 || lookupData !== d || lookupByte !== 1'(i & 1))
                $display("FAIL wrap%0d got %b/%h/%b exp=1/%h/%b", i, lookupHit, lookupData, lookupByte, d, 1'(i & 1));
            else n_pass++;
        end
        lookupReq = 1'b0;
        drain_all();
    endtask

    task automatic test_reset_mid();
        int n = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h700 + 32'(4 * i), 32'h70 + 32'(i), 0, 0);
            tick();
        end
        push = 1'b0;
        #1;
        while (!memReq && n < 10) begin tick(); n++; end
        n_total++; if (memReq !== 1'b1 || overflow !== 1'b1) $display("FAIL rmid_pre got req=%b ovf=%b exp=1/1", memReq, overflow); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0; lookupReq = 1'b1; lookupAddr = 32'h700;
        #1;
        n_total++; if (memReq !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0 || lookupHit !== 1'b0)
            $display("FAIL rmid_post got req=%b empty=%b ovf=%b hit=%b exp=0/1/0/0", memReq, empty, overflow, lookupHit);
        else n_pass++;
        lookupReq = 1'b0;
    endtask

    task automatic test_random();
        st_t e;
        bit  h;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 99) < 60, 32'h800 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                  $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 40);
            lookupReq = 1'($urandom_range(0, 1));
            lookupAddr = 32'h800 + 32'(4 * $urandom_range(0, 8)) + 32'($urandom_range(0, 3));
            #1;
            h = mlook(lookupAddr, e) && lookupReq;
            n_total++; if ({memReq, full, empty, overflow, lookupHit} !== {m_req, q.size() == SB_SLOTS, q.size() == 0, m_ovf, h})
                $display("FAIL rnd_status c=%0d got=%b exp=%b", c, {memReq, full, empty, overflow, lookupHit},
                         {m_req, q.size() == SB_SLOTS, q.size() == 0, m_ovf, h});
            else n_pass++;
            if (h) begin
                n_total++; if (lookupData !== e.d || lookupAddrOut !== e.a || lookupByte !== e.b)
                    $display("FAIL rnd_fwd c=%0d got %h/%h/%b exp=%h/%h/%b", c, lookupData, lookupAddrOut, lookupByte, e.d, e.a, e.b);
                else n_pass++;
            end
            if (m_req && q.size() != 0) begin
                n_total++; if (memAddr !== q[0].a || memData !== q[0].d || memByte !== q[0].b)
                    $display("FAIL rnd_head c=%0d got %h/%h/%b exp=%h/%h/%b", c, memAddr, memData, memByte, q[0].a, q[0].d, q[0].b);
                else n_pass++;
            end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        lookupReq = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_simul();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Post-commit store buffer between the reorder buffer's memory-write commit port and the data cache write port. It accepts one committed store per cycle into a circular FIFO and drains entries to the dCache in order through a req/ack handshake. It also answers load-forwarding lookups from the youngest buffered store to the same word. Pipeline `clear` does not flush it, because buffered stores are already architecturally committed.

## Interface
Parameters:
- `ARCH_BITS`, 32, address and data width
- `SB_SLOTS`, 4, number of entries (power of two, ≥2)
- `SB_IDX_BITS`, 2, log2(`SB_SLOTS`)
- `BYTE_IDX_BITS`, 2, byte-offset bits ignored in word compare

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `push`  in  1  committed store valid (ROB `wEnableMem`)
- `pushAddr`  in  ARCH_BITS  store address
- `pushData`  in  ARCH_BITS  store data
- `pushByte`  in  1  byte store (1) / word store (0)
- `full`  out  1  count == SB_SLOTS; ROB must not commit a store while high
- `empty`  out  1  count == 0
- `overflow`  out  1  sticky: push seen while full
- `memReq`  out  1  drain request to dCache
- `memAddr`  out  ARCH_BITS  head address
- `memData`  out  ARCH_BITS  head data
- `memByte`  out  1  head byte flag
- `memAck`  in  1  dCache accepted head store this cycle
- `lookupReq`  in  1  load forwarding query
- `lookupAddr`  in  ARCH_BITS  load address
- `lookupHit`  out  1  matching entry found
- `lookupData`  out  ARCH_BITS  data of youngest match
- `lookupAddrOut`  out  ARCH_BITS  full address of youngest match
- `lookupByte`  out  1  byte flag of youngest match

## Operation
- State: per-entry addr/data/byte arrays, `head`, `tail` (SB_IDX_BITS), `count` (SB_IDX_BITS+1 bits, 0..SB_SLOTS).
- Push: when `push && !full`, the entry at `tail` is written and `tail` advances by 1 mod SB_SLOTS. When `push && full`, the store is dropped, `overflow` is set, and no other state changes.
- Drain FSM:
  - S_IDLE: `memReq`=0. Goes to S_REQ when `count != 0`.
  - S_REQ: `memReq`=1, and `memAddr`/`memData`/`memByte` show the head entry. On `memAck`, `head` advances by 1 mod SB_SLOTS. The FSM returns to S_IDLE if the post-update count is 0, otherwise it stays in S_REQ.
  - `memAck` outside S_REQ is ignored.
- Count update: +1 on an accepted push, −1 on an ack in S_REQ. A simultaneous push and ack leaves count unchanged. A push while full with an ack in the same cycle is still dropped, because `full` is evaluated before the edge.
- Lookup (combinational):
  - Scan the valid entries from head toward tail.
  - Match when `addr[ARCH_BITS-1:BYTE_IDX_BITS] == lookupAddr[ARCH_BITS-1:BYTE_IDX_BITS]`.
  - The youngest match (closest to tail) wins.
  - `lookupHit` = `lookupReq` && match. Data outputs are don't-care when there is no hit.
- The head entry stays visible to lookup until the edge that acks it. A store pushed in cycle N is not visible to lookup until cycle N+1.
- Reset: head=tail=count=0, FSM=S_IDLE, `overflow`=0.
  - Output values after reset: `memReq`=0, `full`=0, `empty`=1, `lookupHit`=0.
  - Entry contents are not reset.
  - Reset mid-drain discards all entries, and `memReq` drops the cycle after the reset edge.

## Timing
- Push to `memReq`: the store pushed at edge N gives `memReq`=1 in the cycle after edge N+1 (one FSM registration cycle) when the buffer was empty.
- Back-to-back drain: with `memAck` held high, one entry retires per cycle and `memReq` stays high with no bubble.
- `memAddr`/`memData`/`memByte` stay stable while `memReq`=1 and `memAck`=0.
- `full`, `empty`, `lookup*` are combinational from registered state plus lookup inputs. There is no dependency path from `push` to `full`.
- Wrap-around: indices wrap from SB_SLOTS−1 to 0, and the lookup scan crosses the wrap correctly.

## Structure
- The shared processor package holds `ARCH_BITS`, `BYTE_IDX_BITS`, `SB_SLOTS`, `SB_IDX_BITS` and the FSM state encoding (S_IDLE=0, S_REQ=1).
- One natural sub-module: `sb_fwd_match`, the combinational youngest-match priority scan over entries given head and count.

## Test plan
- Single store: push addr 0x100 data 0xDEAD_BEEF → `memReq`=1 two cycles later with those values. Hold `memAck`=0 for 3 cycles → outputs stable. Ack → `empty`=1, `memReq`=0 next cycle.
- Fill: 4 pushes with `memAck`=0 → `full`=1. 5th push → dropped and `overflow`=1. Drain with `memAck`=1 → addresses leave in push order over 4 consecutive cycles.
- Forwarding: push 0x200/0x11, then 0x204/0x22, then 0x201 (byte)/0x33. Lookup 0x202 → hit, data 0x33, `lookupAddrOut`=0x201, `lookupByte`=1. Lookup 0x208 → no hit.
- Simultaneous push and ack when count=2 → count stays 2. Head and tail each advance by 1.
- Wrap: 6 push/ack pairs interleaved so that tail wraps past 3→0. Lookup of the newest entry hits with correct data.
- Reset with 3 entries pending and `memReq`=1 → next cycle `memReq`=0, `empty`=1, `overflow`=0, and lookups miss.
